imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Writer side of the instruction memory. The core's fetch path only reads IMEM; this block fills it from a byte stream, for example from a UART RX or a debug bridge.
- Holds the core in reset while loading. Releases it once the last word is written.
- Sits at top level between the byte source and the IMEM write port. Its `core_hold` output is ORed into the core's `reset`.

Parameters:
- IMEM_SIZE, 128, IMEM depth in 32-bit words. Must equal the core's IMEM_SIZE.
- AW, $clog2(IMEM_SIZE), width of the IMEM word address (derived, do not override).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle pulse; re-arms loading from DONE or ERR
- in_valid  in  1  byte source has a byte
- in_data  in  8  byte payload
- in_ready  out  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
- imem_we  out  1  IMEM write strobe, one cycle per word
- imem_waddr  out  AW  word address, not byte address
- imem_wdata  out  32  assembled word
- core_hold  out  1  hold the core in reset
- done  out  1  load completed successfully
- error  out  1  load aborted
- words_loaded  out  16  count of words written in the current load

Behaviour:
- Frame format: 2-byte word count N (little-endian), then N words of 4 bytes each (little-endian, byte 0 → bits [7:0]).
- FSM states: HDR_LO, HDR_HI, DATA, DONE, ERR.
- Reset values: state=HDR_LO, core_hold=1, done=0, error=0, imem_we=0, imem_waddr=0, imem_wdata=0, words_loaded=0, byte index=0.
- in_ready is 1 in HDR_LO, HDR_HI and DATA; it is 0 in DONE and ERR. There is no back-pressure from IMEM writes.
- HDR_LO: on transfer, latch N[7:0] → HDR_HI.
- HDR_HI: on transfer, latch N[15:8]. Next state:
  - N==0 → DONE.
  - N>IMEM_SIZE → ERR.
  - otherwise → DATA.
- DATA: a 2-bit byte index selects the byte lane. When the 4th byte of a word transfers:
  - Next cycle: imem_we=1 for exactly one cycle, imem_waddr = word index, imem_wdata = assembled word, words_loaded increments.
  - Byte index wraps to 0.
  - The next word's first byte may transfer in that same write cycle.
- Completion: on the 4th byte of word N-1, the state goes to DONE at the same edge that raises imem_we. In DONE, done=1 and core_hold=0, so the core exits reset the cycle after the final write. imem_we is still 1 during that first DONE cycle.
- ERR: error=1 and core_hold=1. Sticky until start or reset.
- start in DONE or ERR:
  - Next state HDR_LO; core_hold=1, done=0, error=0.
  - words_loaded=0, byte index=0, word index=0.
- start in any other state is ignored.
- reset mid-load: abort immediately to reset values. No partial write is issued. IMEM contents already written are undefined for use.
- Transfer with in_valid=0: nothing happens; gaps between bytes are unlimited.
- imem_waddr never exceeds IMEM_SIZE-1; this is guaranteed by the N check.

Optional Feature:
- Macro: IMEM_LOADER_CSUM_EN.
- Enabled:
  - A running XOR covers every header and payload byte.
  - After the last data byte (or after HDR_HI when N==0), an extra state CSUM accepts one trailer byte.
  - Trailer equal to the running XOR → DONE; otherwise → ERR.
  - The final imem_we still fires; error blocks core release.
  - The checksum register resets to 0 on reset and on start.
- Disabled: no CSUM state and no trailer byte; timing is exactly as above.

Decomposition:
- Package imem_loader_pkg holds:
  - the state enum (HDR_LO, HDR_HI, DATA, CSUM, DONE, ERR);
  - localparam HDR_BYTES=2;
  - localparam BYTES_PER_WORD=4.
- One natural sub-module, byte_word_assembler: shifts 4 bytes into a 32-bit word and emits a word_valid pulse. The FSM and counters stay in imem_loader.

Test Plan:
- Normal load: N=2, bytes 02 00 | 13 05 A0 00 | 6F 00 00 00 → two writes, addr0=0x00A00513 then addr1=0x0000006F. After that, done=1, core_hold=0, words_loaded=2.
- Gapped stream: same frame with in_valid low for 3 random cycles between bytes → identical writes and values, no extra imem_we pulses.
- Bad length: header 0x0081 with IMEM_SIZE=128 → error=1, in_ready=0, no imem_we, core_hold=1. Then start → HDR_LO with error=0.
- Zero length: header 00 00 → done=1 in the cycle after the 2nd header byte, no writes.
- Reset mid-load: assert reset after byte 2 of word 1 → all outputs at reset values, no imem_we. A fresh N=1 frame then writes addr0 correctly.
- With IMEM_LOADER_CSUM_EN, N=1, payload 01 02 03 04:
  - Trailer 0x05 (01^00^01^02^03^04) → done=1.
  - Trailer 0x06 → error=1, core_hold=1.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the IMEM loader.
//   state_e        : loader FSM states (CSUM is only reached when
//                    IMEM_LOADER_CSUM_EN is defined)
//   HDR_BYTES      : number of header bytes (little-endian word count)
//   BYTES_PER_WORD : payload bytes per 32-bit IMEM word
package imem_loader_pkg;

  typedef enum logic [2:0] {
    HDR_LO = 3'd0,
    HDR_HI = 3'd1,
    DATA   = 3'd2,
    CSUM   = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_e;

  localparam int HDR_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: bundles the byte stream, IMEM write port and status
// signals of the loader.
//   master : the loader (consumes start/in_valid/in_data, drives the rest)
//   slave  : the surrounding system (byte source, IMEM, core reset logic)
// Parameter AW is the IMEM word-address width.
interface imem_loader_if #(
  parameter int AW = 7
);
  logic          start;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;
  logic [15:0]   words_loaded;

  modport master (
    input  start, in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata,
           core_hold, done, error, words_loaded
  );

  modport slave (
    output start, in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata,
           core_hold, done, error, words_loaded
  );
endinterface

// File: rtl/imem_loader_byte_word_assembler.sv
// byte_word_assembler: collects 4 bytes (little-endian, first byte into
// bits [7:0]) into a 32-bit word and emits a one-cycle o_word_valid pulse
// in the cycle after the 4th byte is accepted.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   i_clear        : restart at byte lane 0, drop any pending pulse
//   i_byte_valid   : accept i_byte_data this cycle
//   i_byte_data    : byte payload
//   o_byte_idx     : lane the next accepted byte lands in
//   o_word_valid   : one-cycle pulse, o_word holds the assembled word
//   o_word         : last assembled word (held until the next one)
module byte_word_assembler
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte_data,
  output logic [1:0]  o_byte_idx,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  localparam logic [1:0] LAST_LANE = 2'(BYTES_PER_WORD - 1);

  logic [1:0]  r_byte_idx;
  logic        r_word_valid;
  logic [31:0] r_word;
  logic [7:0]  r_lane [BYTES_PER_WORD-1];

  // Lower lanes are parked here; the top lane goes straight into r_word.
  genvar gi;
  generate
    for (gi = 0; gi < BYTES_PER_WORD - 1; gi++) begin : g_lane
      always_ff @(posedge clk) begin
        if (reset) begin
          r_lane[gi] <= 8'h00;
        end else if (i_byte_valid && !i_clear && r_byte_idx == 2'(gi)) begin
          r_lane[gi] <= i_byte_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_byte_idx   <= 2'd0;
      r_word_valid <= 1'b0;
      r_word       <= 32'h0;
    end else if (i_clear) begin
      r_byte_idx   <= 2'd0;
      r_word_valid <= 1'b0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_byte_valid) begin
        if (r_byte_idx == LAST_LANE) begin
          r_byte_idx   <= 2'd0;
          r_word_valid <= 1'b1;
          r_word       <= {i_byte_data, r_lane[2], r_lane[1], r_lane[0]};
        end else begin
          r_byte_idx <= r_byte_idx + 2'd1;
        end
      end
    end
  end

  assign o_byte_idx   = r_byte_idx;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// imem_loader: fills instruction memory from a byte stream and holds the
// core in reset until the load completes.
// Frame: 2-byte little-endian word count N, then N little-endian words.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   bus        : imem_loader_if.master (start, byte stream, IMEM write
//                port, core_hold/done/error status, words_loaded)
// Optional build macro IMEM_LOADER_CSUM_EN: adds an XOR checksum trailer
// byte checked in state CSUM before DONE.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int IMEM_SIZE = 128,
  parameter int AW        = $clog2(IMEM_SIZE)
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.master bus
);

`ifdef IMEM_LOADER_CSUM_EN
  localparam state_e END_STATE = CSUM;
`else
  localparam state_e END_STATE = DONE;
`endif

  state_e        r_state, w_state_next;
  logic [7:0]    r_n_lo;
  logic [15:0]   r_n;
  logic [15:0]   r_words_loaded;
  logic [AW-1:0] r_waddr;

  logic          w_in_ready, w_xfer, w_rearm;
  logic          w_done, w_error, w_core_hold;
  logic [15:0]   w_n_full;
  logic [1:0]    w_byte_idx;
  logic          w_data_xfer, w_last_byte, w_last_word;
  logic          w_word_valid;
  logic [31:0]   w_word;

  assign w_xfer      = bus.in_valid & w_in_ready;
  assign w_rearm     = bus.start & ((r_state == DONE) | (r_state == ERR));
  assign w_n_full    = {bus.in_data, r_n_lo};
  assign w_data_xfer = (r_state == DATA) & w_xfer;
  assign w_last_byte = w_data_xfer & (w_byte_idx == 2'(BYTES_PER_WORD - 1));
  // The word now completing is word index r_words_loaded.
  assign w_last_word = ((r_words_loaded + 16'd1) == r_n);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= HDR_LO;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_done       = 1'b0;
    w_error      = 1'b0;
    w_core_hold  = 1'b1;
    case (r_state)
      HDR_LO: begin
        w_in_ready = 1'b1;
        if (w_xfer) w_state_next = HDR_HI;
      end
      HDR_HI: begin
        w_in_ready = 1'b1;
        if (w_xfer) begin
          if (w_n_full == 16'd0)                 w_state_next = END_STATE;
          else if (w_n_full > 16'(IMEM_SIZE))    w_state_next = ERR;
          else                                   w_state_next = DATA;
        end
      end
      DATA: begin
        w_in_ready = 1'b1;
        if (w_last_byte && w_last_word) w_state_next = END_STATE;
      end
      CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
        w_in_ready = 1'b1;
        if (w_xfer) w_state_next = (bus.in_data == r_csum) ? DONE : ERR;
`else
        w_state_next = ERR;
`endif
      end
      DONE: begin
        w_done      = 1'b1;
        w_core_hold = 1'b0;
        if (bus.start) w_state_next = HDR_LO;
      end
      ERR: begin
        w_error = 1'b1;
        if (bus.start) w_state_next = HDR_LO;
      end
      default: w_state_next = HDR_LO;
    endcase
  end

  // Word count doubles as the word index of the next IMEM write.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_n_lo         <= 8'h00;
      r_n            <= 16'h0;
      r_words_loaded <= 16'h0;
      r_waddr        <= '0;
    end else if (w_rearm) begin
      r_words_loaded <= 16'h0;
    end else begin
      if (r_state == HDR_LO && w_xfer) r_n_lo <= bus.in_data;
      if (r_state == HDR_HI && w_xfer) r_n    <= w_n_full;
      if (w_last_byte) begin
        r_waddr        <= r_words_loaded[AW-1:0];
        r_words_loaded <= r_words_loaded + 16'd1;
      end
    end
  end

`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0] r_csum;

  always_ff @(posedge clk) begin
    if (reset || w_rearm) begin
      r_csum <= 8'h00;
    end else if (w_xfer && (r_state == HDR_LO || r_state == HDR_HI || r_state == DATA)) begin
      r_csum <= r_csum ^ bus.in_data;
    end
  end
`endif

  byte_word_assembler u_asm (
    .clk          (clk),
    .reset        (reset),
    .i_clear      (w_rearm),
    .i_byte_valid (w_data_xfer),
    .i_byte_data  (bus.in_data),
    .o_byte_idx   (w_byte_idx),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  assign bus.in_ready     = w_in_ready;
  assign bus.imem_we      = w_word_valid;
  assign bus.imem_waddr   = r_waddr;
  assign bus.imem_wdata   = w_word;
  assign bus.core_hold    = w_core_hold;
  assign bus.done         = w_done;
  assign bus.error        = w_error;
  assign bus.words_loaded = r_words_loaded;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench for imem_loader. Frames are built from
// the frame rules (count header, little-endian words, optional XOR trailer
// when IMEM_LOADER_CSUM_EN is defined); every expected IMEM write is queued
// as its last byte is driven and a negedge monitor pops and compares each
// imem_we pulse.
module tb_imem_loader;

  localparam int IMEM_SIZE = 128;
  localparam int AW        = 7;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;
  wr_t  exp_q[$];
  wr_t  mon_e;
  logic [31:0] dir_words[$];

  imem_loader_if #(.AW(AW)) sif ();

  imem_loader #(.IMEM_SIZE(IMEM_SIZE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest queued write.
  always @(negedge clk) begin
    if (sif.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(sif.imem_waddr), mon_e.addr);
        check("wr_data", sif.imem_wdata, mon_e.data);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the byte transferred.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    sif.in_valid = 1'b1;
    sif.in_data  = b;
    while (sif.in_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 50) check("in_ready_timeout", 32'(sif.in_ready), 32'd1);
    @(negedge clk);
  endtask

  task automatic send_gapped(input logic [7:0] b, input int gap);
    int g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
    sif.in_valid = 1'b0;
    repeat (g) @(negedge clk);
    send_byte(b);
  endtask

  task automatic check_final(input bit exp_done, input bit exp_err, input logic [15:0] exp_words);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done", 32'(sif.done), 32'(exp_done));
    check("error", 32'(sif.error), 32'(exp_err));
    check("core_hold", 32'(sif.core_hold), 32'(!exp_done));
    check("in_ready_end", 32'(sif.in_ready), 32'd0);
    check("words_loaded", 32'(sif.words_loaded), 32'(exp_words));
    sif.start = 1'b1;
    @(negedge clk);
    sif.start = 1'b0;
    check("rearm_done", 32'(sif.done), 32'd0);
    check("rearm_error", 32'(sif.error), 32'd0);
    check("rearm_hold", 32'(sif.core_hold), 32'd1);
    check("rearm_ready", 32'(sif.in_ready), 32'd1);
    check("rearm_words", 32'(sif.words_loaded), 32'd0);
  endtask

  // Drives one frame of header value n; words come from dir_words first,
  // then $urandom. bad_trailer corrupts the checksum byte when enabled.
  task automatic send_frame(input logic [15:0] n, input int gap, input bit bad_trailer);
    logic [31:0] w;
    logic [7:0]  x;
    logic [7:0]  b;
    bit          ok_done;
    wr_t         e;
    x = n[7:0] ^ n[15:8];
    send_gapped(n[7:0], gap);
    send_gapped(n[15:8], gap);
    if (int'(n) > IMEM_SIZE) begin
      sif.in_valid = 1'b0;
      check("badlen_error", 32'(sif.error), 32'd1);
      check("badlen_ready", 32'(sif.in_ready), 32'd0);
      check("badlen_hold", 32'(sif.core_hold), 32'd1);
      check_final(1'b0, 1'b1, 16'd0);
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      w = (k < dir_words.size()) ? dir_words[k] : $urandom;
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        x ^= b;
        if (j == 3) begin
          e.addr = 32'(k);
          e.data = w;
          exp_q.push_back(e);
        end
        send_gapped(b, gap);
      end
    end
    sif.in_valid = 1'b0;
    check("final_we", 32'(sif.imem_we), 32'(n != 16'd0));
`ifdef IMEM_LOADER_CSUM_EN
    check("csum_wait_hold", 32'(sif.core_hold), 32'd1);
    ok_done = !bad_trailer;
    send_gapped(bad_trailer ? (x ^ 8'h03) : x, gap);
    sif.in_valid = 1'b0;
`else
    ok_done = 1'b1;
`endif
    check("end_done", 32'(sif.done), 32'(ok_done));
    check("end_hold", 32'(sif.core_hold), 32'(!ok_done));
    check_final(ok_done, !ok_done, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    reset = 1'b1;
    sif.start = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_hold", 32'(sif.core_hold), 32'd1);
    check("rst_done", 32'(sif.done), 32'd0);
    check("rst_error", 32'(sif.error), 32'd0);
    check("rst_we", 32'(sif.imem_we), 32'd0);
    check("rst_waddr", 32'(sif.imem_waddr), 32'd0);
    check("rst_wdata", sif.imem_wdata, 32'd0);
    check("rst_words", 32'(sif.words_loaded), 32'd0);
    check("rst_ready", 32'(sif.in_ready), 32'd1);

    // Normal load, then the same frame with 3-cycle gaps.
    dir_words = '{32'h00A00513, 32'h0000006F};
    send_frame(16'd2, 0, 1'b0);
    send_frame(16'd2, 3, 1'b0);
    // Bad length and zero length.
    send_frame(16'h0081, 0, 1'b0);
    send_frame(16'd0, 0, 1'b0);

    // Reset mid-load after byte 2 of word 1.
    send_byte(8'h02);
    send_byte(8'h00);
    mon_e.addr = 32'd0;
    mon_e.data = 32'h00A00513;
    exp_q.push_back(mon_e);
    send_byte(8'h13);
    send_byte(8'h05);
    send_byte(8'hA0);
    send_byte(8'h00);
    send_byte(8'h6F);
    send_byte(8'h00);
    sif.in_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_hold", 32'(sif.core_hold), 32'd1);
    check("mid_rst_done", 32'(sif.done), 32'd0);
    check("mid_rst_we", 32'(sif.imem_we), 32'd0);
    check("mid_rst_waddr", 32'(sif.imem_waddr), 32'd0);
    check("mid_rst_wdata", sif.imem_wdata, 32'd0);
    check("mid_rst_words", 32'(sif.words_loaded), 32'd0);
    check("mid_rst_queue", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    dir_words = '{32'hDEADBEEF};
    send_frame(16'd1, 0, 1'b0);

`ifdef IMEM_LOADER_CSUM_EN
    dir_words = '{32'h04030201};
    send_frame(16'd1, 0, 1'b0);
    send_frame(16'd1, 0, 1'b1);
`endif

    // Boundary: largest legal frame fills every address.
    dir_words.delete();
    send_frame(16'(IMEM_SIZE), 0, 1'b0);

    // Randomized frames.
    for (int f = 0; f < 14; f++) begin
      int sel = int'($urandom_range(0, 9));
      logic [15:0] n;
      if (sel == 0)      n = 16'd0;
      else if (sel == 1) n = 16'($urandom_range(IMEM_SIZE + 1, 16'hFFFF));
      else               n = 16'($urandom_range(1, 8));
      send_frame(n, -1, bit'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
